// File: rtl/matmul_seq.sv
// Loop sequencer for the matrix-multiply datapath: walks (i, j, k) over an
// (M x K)*(K x N) product and emits operand addresses plus MAC/write strobes.
module matmul_seq #(
    parameter int DIM_W = 4,
    localparam int ADDR_W = 2 * DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  n_dim,
    input  logic [DIM_W-1:0]  k_dim,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              c_we,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_W-1:0]  m_lim_q, m_lim_d, n_lim_q, n_lim_d, k_lim_q, k_lim_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            m_lim_q <= '0;
            n_lim_q <= '0;
            k_lim_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            m_lim_q <= m_lim_d;
            n_lim_q <= n_lim_d;
            k_lim_q <= k_lim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        m_lim_d = m_lim_q;
        n_lim_d = n_lim_q;
        k_lim_d = k_lim_q;
        case (state_q)
            S_IDLE: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (start) begin
                    m_lim_d = m_dim;
                    n_lim_d = n_dim;
                    k_lim_d = k_dim;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!stall) state_d = S_MAC;
            end
            S_MAC: begin
                // k stops at its limit rather than wrapping; WRITE resets it.
                if (!stall) begin
                    if (k_q == k_lim_q) state_d = S_WRITE;
                    else                k_d     = k_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (!stall) begin
                    k_d = '0;
                    if (j_q != n_lim_q) begin
                        j_d     = j_q + 1'b1;
                        state_d = S_CLEAR;
                    end else if (i_q != m_lim_q) begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by stall; addresses track the held indices.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mac_clr   = (state_q == S_CLEAR) && !stall;
    assign mac_en    = (state_q == S_MAC)   && !stall;
    assign c_we      = (state_q == S_WRITE) && !stall;
    assign a_addr    = {i_q, k_q};
    assign b_addr    = {k_q, j_q};
    assign c_addr    = {i_q, j_q};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: row-major scoreboard of c_addr, per-step
// operand address checks, stall/start-while-busy/reset-mid-job scenarios.
module tb_matmul_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] m_dim, n_dim, k_dim;
    logic       stall;
    logic       busy, done, mac_clr, mac_en, c_we;
    logic [7:0] a_addr, b_addr, c_addr;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    matmul_seq #(.DIM_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .m_dim     (m_dim),
        .n_dim     (n_dim),
        .k_dim     (k_dim),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .c_we      (c_we),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({busy, done, mac_clr, mac_en, c_we, a_addr, b_addr, c_addr}), 32'd0);
    endtask

    task automatic run_job(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k,
                           input logic start_stall, input int stall_at, input int stall_len,
                           input logic [7:0] hold_a, input int sb_at, input int exp_done);
        int  rel;
        int  macs;
        bit  seen_done;
        bit  first_clr;
        logic [3:0] kk;
        exp_q.delete();
        for (int i = 0; i <= int'(m); i++)
            for (int j = 0; j <= int'(n); j++)
                exp_q.push_back({4'(i), 4'(j)});
        m_dim = m;
        n_dim = n;
        k_dim = k;
        stall = start_stall;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        macs = 0;
        seen_done = 0;
        first_clr = 1;
        for (rel = 1; rel <= exp_done + 4 && !seen_done; rel++) begin
            stall = (stall_at > 0) && (rel >= stall_at) && (rel < stall_at + stall_len);
            if (rel == sb_at) begin
                start = 1'b1;
                m_dim = 4'd3;
                n_dim = 4'd3;
                k_dim = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (stall) begin
                check("stall_strobes", 32'({mac_clr, mac_en, c_we}), 32'd0);
                check("stall_a_addr", 32'(a_addr), 32'(hold_a));
            end
            if (mac_clr) begin
                if (first_clr) check("first_clr_cycle", 32'(rel), 32'd1);
                first_clr = 0;
                check("clr_mac_count", 32'(macs), 32'd0);
            end
            if (mac_en) begin
                if (exp_q.size() == 0) begin
                    check("extra_mac_en", 32'd1, 32'd0);
                end else begin
                    kk = macs[3:0];
                    check("a_addr", 32'(a_addr), 32'({exp_q[0][7:4], kk}));
                    check("b_addr", 32'(b_addr), 32'({kk, exp_q[0][3:0]}));
                end
                macs++;
            end
            if (c_we) begin
                if (exp_q.size() == 0) begin
                    check("extra_c_we", 32'd1, 32'd0);
                end else begin
                    check("c_addr", 32'(c_addr), 32'(exp_q.pop_front()));
                end
                check("mac_count", 32'(macs), 32'(k) + 32'd1);
                macs = 0;
            end
            if (done) begin
                check("done_cycle", 32'(rel), 32'(exp_done));
                seen_done = 1;
            end else begin
                check("busy_high", 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        check("elements_left", 32'(exp_q.size()), 32'd0);
        stall = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        m_dim = '0;
        n_dim = '0;
        k_dim = '0;
        #2;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
        @(posedge clk);
        #1;

        // minimal job, start accepted while stall=1 in IDLE
        run_job(4'd0, 4'd0, 4'd0, 1'b1, 0, 0, 8'h00, 0, 4);
        // 2x3 * 3x2
        run_job(4'd1, 4'd1, 4'd2, 1'b0, 0, 0, 8'h00, 0, 21);
        // stall 4 cycles at second MAC of element (0,1)
        run_job(4'd1, 4'd1, 4'd2, 1'b0, 8, 4, 8'h01, 0, 25);
        // start pulsed mid-job with new dims: ignored
        run_job(4'd1, 4'd1, 4'd1, 1'b0, 0, 0, 8'h00, 5, 17);
        // non-square job
        run_job(4'd2, 4'd0, 4'd3, 1'b0, 0, 0, 8'h00, 0, 19);

        // reset during WRITE
        m_dim = 4'd0;
        n_dim = 4'd0;
        k_dim = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (c_we) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("reach_write", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("after_reset_c_we", 32'(c_we), 32'd0);
            check("after_reset_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        run_job(4'd0, 4'd0, 4'd1, 1'b0, 0, 0, 8'h00, 0, 5);

        // max dims
        run_job(4'd15, 4'd15, 4'd15, 1'b0, 0, 0, 8'h00, 0, 4609);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
